vc_arbiter_demux: RTL and testbench

//  Downstream stage of the VC0/VC1 FIFO pair. Arbitrates pops between the two
//  VC FIFOs (VC0 priority, VC1 starvation guard) and routes each popped word to

---
 rtl/vc_arbiter_demux.sv | 88 ++++++++
 tb/tb_vc_arbiter_demux.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter_demux.sv
// vc_arbiter_demux: arbitrates pops between the VC0/VC1 FIFOs and routes each popped word to D0/D1
// VC0 has priority but yields to a waiting VC1 after VC0_BURST consecutive pops.
module vc_arbiter_demux #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4,
  parameter int VC0_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic [DATA_WIDTH-1:0] data_out_VC0,
  input  logic [DATA_WIDTH-1:0] data_out_VC1,
  input  logic                  pause_d0,
  input  logic                  pause_d1,
  output logic                  pop_VC0,
  output logic                  pop_VC1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_out_d0,
  output logic [DATA_WIDTH-1:0] data_out_d1,
  output logic [7:0]            count_d0,
  output logic [7:0]            count_d1,
  output logic                  idle
);
  typedef enum logic [1:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE} state_t;
  state_t state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic s1_valid_q, s1_valid_d, s1_src_q, s1_src_d;
  logic push_d0_q, push_d0_d, push_d1_q, push_d1_d;
  logic [DATA_WIDTH-1:0] data_d0_q, data_d0_d, data_d1_q, data_d1_d, word;
  logic [7:0] count_d0_q, count_d0_d, count_d1_q, count_d1_d;
  logic can_pop, pipe_busy;
  // Any pause blocks pops: the destination is only known once the word is read.
  always_comb begin
    can_pop    = (state_q == S_IDLE || state_q == S_ACTIVE) && !init && !pause_d0 && !pause_d1;
    pop_VC0    = can_pop && !empty_fifo_VC0 && !(burst_q == 4'(VC0_BURST) && !empty_fifo_VC1);
    pop_VC1    = can_pop && !empty_fifo_VC1 && !pop_VC0;
    pipe_busy  = s1_valid_q || push_d0_q || push_d1_q;
    idle       = state_q == S_IDLE && !pop_VC0 && !pop_VC1 && !pipe_busy;
    word       = s1_src_q ? data_out_VC1 : data_out_VC0;
    state_d    = init ? S_INIT :
                 state_q == S_RESET ? S_INIT :
                 state_q == S_INIT ? S_IDLE :
                 (!empty_fifo_VC0 || !empty_fifo_VC1 || pipe_busy) ? S_ACTIVE : S_IDLE;
    burst_d    = (init || pop_VC1 || empty_fifo_VC1) ? '0 : burst_q + 4'(pop_VC0);
    s1_valid_d = pop_VC0 || pop_VC1;
    s1_src_d   = pop_VC1;
    push_d0_d  = !init && s1_valid_q && !word[DEST_BIT];
    push_d1_d  = !init && s1_valid_q && word[DEST_BIT];
    data_d0_d  = init ? '0 : push_d0_d ? word : data_d0_q;
    data_d1_d  = init ? '0 : push_d1_d ? word : data_d1_q;
    count_d0_d = init ? '0 : count_d0_q + 8'(push_d0_d);
    count_d1_d = init ? '0 : count_d1_q + 8'(push_d1_d);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RESET;
      burst_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_src_q   <= 1'b0;
      push_d0_q  <= 1'b0;
      push_d1_q  <= 1'b0;
      data_d0_q  <= '0;
      data_d1_q  <= '0;
      count_d0_q <= '0;
      count_d1_q <= '0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      s1_valid_q <= s1_valid_d;
      s1_src_q   <= s1_src_d;
      push_d0_q  <= push_d0_d;
      push_d1_q  <= push_d1_d;
      data_d0_q  <= data_d0_d;
      data_d1_q  <= data_d1_d;
      count_d0_q <= count_d0_d;
      count_d1_q <= count_d1_d;
    end
  end
  assign push_d0     = push_d0_q;
  assign push_d1     = push_d1_q;
  assign data_out_d0 = data_d0_q;
  assign data_out_d1 = data_d1_q;
  assign count_d0    = count_d0_q;
  assign count_d1    = count_d1_q;
endmodule

// File: tb/tb_vc_arbiter_demux.sv
// tb_vc_arbiter_demux: directed bench with a queue-based reference model checked every cycle
module tb_vc_arbiter_demux;
  localparam int DW = 6, DB = 4, VB = 4;
  logic clk = 1'b0, reset, init, empty_fifo_VC0, empty_fifo_VC1, pause_d0, pause_d1;
  logic [DW-1:0] data_out_VC0, data_out_VC1, data_out_d0, data_out_d1;
  logic pop_VC0, pop_VC1, push_d0, push_d1, idle;
  logic [7:0] count_d0, count_d1;
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [DW-1:0] q0[$], q1[$];
  typedef struct {logic [DW-1:0] w; int due;} fl_t;
  typedef struct {int c; logic d; logic [DW-1:0] w;} ev_t;
  fl_t infl[$];
  ev_t pushes[$];
  logic pops[$];
  int m_mode = 0, m_burst = 0, m_c0 = 0, m_c1 = 0;
  logic [DW-1:0] m_l0 = '0, m_l1 = '0, fw;
  logic e0, e1, can, x0, x1, xp0, xp1, busy, xi;

  always #5 clk = ~clk;

  vc_arbiter_demux #(.DATA_WIDTH(DW), .DEST_BIT(DB), .VC0_BURST(VB)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_fifo_VC0(empty_fifo_VC0), .empty_fifo_VC1(empty_fifo_VC1),
    .data_out_VC0(data_out_VC0), .data_out_VC1(data_out_VC1),
    .pause_d0(pause_d0), .pause_d1(pause_d1),
    .pop_VC0(pop_VC0), .pop_VC1(pop_VC1), .push_d0(push_d0), .push_d1(push_d1),
    .data_out_d0(data_out_d0), .data_out_d1(data_out_d1),
    .count_d0(count_d0), .count_d1(count_d1), .idle(idle)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: words in flight are kept with the cycle they must appear on D0/D1.
  always @(negedge clk) begin
    if (!reset) begin
      m_mode = 0; m_burst = 0; m_c0 = 0; m_c1 = 0; m_l0 = '0; m_l1 = '0;
      infl.delete();
      chk("rst_pop", {pop_VC0, pop_VC1}, 0);
      chk("rst_push", {push_d0, push_d1}, 0);
      chk("rst_data", {data_out_d0, data_out_d1}, 0);
      chk("rst_count", {count_d0, count_d1}, 0);
      chk("rst_idle", idle, 0);
    end else begin
      e0 = empty_fifo_VC0; e1 = empty_fifo_VC1;
      can = m_mode >= 2 && !init && !pause_d0 && !pause_d1;
      x0 = can && !e0 && !(m_burst == VB && !e1);
      x1 = can && !e1 && !x0;
      busy = infl.size() != 0;
      xp0 = 1'b0; xp1 = 1'b0;
      if (infl.size() != 0 && infl[0].due == cyc) begin
        fw = infl[0].w;
        if (fw[DB]) begin xp1 = 1'b1; m_l1 = fw; m_c1 = (m_c1 + 1) % 256; end
        else begin xp0 = 1'b1; m_l0 = fw; m_c0 = (m_c0 + 1) % 256; end
      end
      xi = m_mode == 2 && !x0 && !x1 && !busy;
      chk("pop_VC0", pop_VC0, x0);
      chk("pop_VC1", pop_VC1, x1);
      chk("push_d0", push_d0, xp0);
      chk("push_d1", push_d1, xp1);
      chk("data_out_d0", data_out_d0, m_l0);
      chk("data_out_d1", data_out_d1, m_l1);
      chk("count_d0", count_d0, m_c0);
      chk("count_d1", count_d1, m_c1);
      chk("idle", idle, xi);
      if (push_d0) pushes.push_back('{c: cyc, d: 1'b0, w: data_out_d0});
      if (push_d1) pushes.push_back('{c: cyc, d: 1'b1, w: data_out_d1});
      if (pop_VC0 || pop_VC1) pops.push_back(pop_VC1);
      while (infl.size() != 0 && infl[0].due <= cyc) void'(infl.pop_front());
      if (x0) infl.push_back('{w: q0[0], due: cyc + 2});
      if (x1) infl.push_back('{w: q1[0], due: cyc + 2});
      if (init) m_mode = 1;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) m_mode = 2;
      else if (m_mode == 2) m_mode = (!e0 || !e1) ? 3 : 2;
      else m_mode = (e0 && e1 && !busy) ? 2 : 3;
      m_burst = (x1 || e1) ? 0 : m_burst + (x0 ? 1 : 0);
      if (init) begin
        infl.delete(); m_c0 = 0; m_c1 = 0; m_l0 = '0; m_l1 = '0; m_burst = 0;
      end
    end
    cyc++;
  end

  // Upstream FIFO behaviour: a pop at cycle t presents its word during t+1.
  task automatic tick(int n = 1);
    logic a0, a1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a0 = pop_VC0; a1 = pop_VC1;
      @(posedge clk);
      #1;
      if (a0 && q0.size() != 0) data_out_VC0 = q0.pop_front();
      if (a1 && q1.size() != 0) data_out_VC1 = q1.pop_front();
      empty_fifo_VC0 = q0.size() == 0;
      empty_fifo_VC1 = q1.size() == 0;
    end
  endtask

  task automatic load(int vc, logic [DW-1:0] w);
    if (vc != 0) q1.push_back(w); else q0.push_back(w);
    empty_fifo_VC0 = q0.size() == 0;
    empty_fifo_VC1 = q1.size() == 0;
  endtask

  task automatic flush();
    q0.delete(); q1.delete();
    empty_fifo_VC0 = 1'b1; empty_fifo_VC1 = 1'b1;
  endtask

  initial begin
    int s, t0, tp, tr, n;
    logic [19:0] seq;
    reset = 1'b1; init = 1'b0; pause_d0 = 1'b0; pause_d1 = 1'b0;
    empty_fifo_VC0 = 1'b1; empty_fifo_VC1 = 1'b1; data_out_VC0 = '0; data_out_VC1 = '0;
    #1 reset = 1'b0;
    tick(3);
    chk("t1_rst_push", {push_d0, push_d1}, 0);
    chk("t1_rst_idle", idle, 0);
    reset = 1'b1; tick(1);
    init = 1'b1; tick(1);
    init = 1'b0; tick(1);
    chk("t1_idle", idle, 1);
    chk("t1_count", {count_d0, count_d1}, 0);

    s = pushes.size(); t0 = cyc;
    load(0, 6'h05); load(0, 6'h15);
    #1 chk("t2_pop", pop_VC0, 1);
    tick(6);
    chk("t2_npush", pushes.size() - s, 2);
    if (pushes.size() >= s + 2) begin
      chk("t2_a_cyc", pushes[s].c, t0 + 2);
      chk("t2_a_dst", pushes[s].d, 0);
      chk("t2_a_dat", pushes[s].w, 6'h05);
      chk("t2_b_cyc", pushes[s+1].c, t0 + 3);
      chk("t2_b_dst", pushes[s+1].d, 1);
      chk("t2_b_dat", pushes[s+1].w, 6'h15);
    end
    chk("t2_count", {count_d0, count_d1}, 16'h0101);
    chk("t2_hold", {data_out_d0, data_out_d1}, {6'h05, 6'h15});

    s = pops.size();
    for (int i = 0; i < 10; i++) begin
      load(0, 6'(i * 3));
      load(1, 6'(6'h30 + i));
    end
    tick(26);
    chk("t3_npop", pops.size() - s, 20);
    seq = '0;
    for (int i = 0; i < 20; i++) seq = {seq[18:0], (s + i < pops.size()) ? pops[s+i] : 1'bx};
    chk("t3_order", seq, 20'b0000_1000_0100_1111_1111);

    s = pushes.size();
    for (int i = 0; i < 8; i++) load(0, 6'(i * 5 + 1));
    tick(2);
    pause_d1 = 1'b1; tp = cyc;
    #1 chk("t4_pop_stop", {pop_VC0, pop_VC1}, 0);
    tick(4);
    pause_d1 = 1'b0;
    #1 chk("t4_pop_resume", pop_VC0, 1);
    tick(12);
    n = 0;
    for (int i = s; i < pushes.size(); i++) if (pushes[i].c >= tp && pushes[i].c < tp + 4) n++;
    chk("t4_skid", n, 2);
    chk("t4_total", pushes.size() - s, 8);

    init = 1'b1; tick(1);
    init = 1'b0; tick(1);
    chk("t5_clr", {count_d0, count_d1}, 0);
    for (int i = 0; i < 256; i++) load(0, 6'(i) & 6'h2F);
    tick(101);
    chk("t5_cnt100", count_d0, 100);
    tick(156);
    chk("t5_wrap", count_d0, 0);
    chk("t5_last_push", push_d0, 1);
    tick(4);
    for (int i = 0; i < 20; i++) load(0, 6'(i) & 6'h2F);
    tick(5);
    init = 1'b1; tick(1);
    #1 chk("t5_init_push", {push_d0, push_d1}, 0);
    chk("t5_init_cnt", {count_d0, count_d1}, 0);
    chk("t5_init_pop", {pop_VC0, pop_VC1}, 0);
    flush(); tick(1);
    init = 1'b0; tick(1);
    chk("t5_idle", idle, 1);

    for (int i = 0; i < 6; i++) load(0, 6'(i * 9));
    tick(3);
    reset = 1'b0;
    #1 chk("t6_push", {push_d0, push_d1}, 0);
    chk("t6_pop", {pop_VC0, pop_VC1}, 0);
    chk("t6_data", {data_out_d0, data_out_d1}, 0);
    flush(); tr = cyc;
    tick(2);
    reset = 1'b1; tick(10);
    n = 0;
    for (int i = 0; i < pushes.size(); i++) if (pushes[i].c >= tr) n++;
    chk("t6_no_push", n, 0);
    chk("t6_count", {count_d0, count_d1}, 0);
    chk("t6_idle", idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
